// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan path: active-high glyphs,
// segment bit positions and a counter-width helper.
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [7:0] SEG_OFF_H = 8'h00;

  localparam logic [7:0] SEG_GLYPH_MASK = 8'(1 << SEG_A) | 8'(1 << SEG_B) |
                                          8'(1 << SEG_C) | 8'(1 << SEG_D) |
                                          8'(1 << SEG_E) | 8'(1 << SEG_F) |
                                          8'(1 << SEG_G);

  localparam logic [7:0] GLYPH_0 = 8'h3F;
  localparam logic [7:0] GLYPH_1 = 8'h06;
  localparam logic [7:0] GLYPH_2 = 8'h5B;
  localparam logic [7:0] GLYPH_3 = 8'h4F;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'h6D;
  localparam logic [7:0] GLYPH_6 = 8'h7D;
  localparam logic [7:0] GLYPH_7 = 8'h07;
  localparam logic [7:0] GLYPH_8 = 8'h7F;
  localparam logic [7:0] GLYPH_9 = 8'h6F;
  localparam logic [7:0] GLYPH_A = 8'h77;
  localparam logic [7:0] GLYPH_B = 8'h7C;
  localparam logic [7:0] GLYPH_C = 8'h39;
  localparam logic [7:0] GLYPH_D = 8'h5E;
  localparam logic [7:0] GLYPH_E = 8'h79;
  localparam logic [7:0] GLYPH_F = 8'h71;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_t;

  // Bits needed to hold a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-high {dp,g,f,e,d,c,b,a} pattern;
// blank clears the glyph segments but keeps the decimal point.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] pattern
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_OFF_H;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_OFF_H;
    endcase
  end

  always_comb begin
    pattern         = blank ? SEG_OFF_H : (glyph & SEG_GLYPH_MASK);
    pattern[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with frame-boundary commit,
// leading-zero blanking, whole-display blink and selectable segment polarity.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned DIG_W          = 3,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [DIG_W-1:0]        digit,
  output logic [7:0]              seg_data,
  output logic                    frame_done
);

  localparam int unsigned PRE_W = cnt_width(SCAN_DIV);
  localparam int unsigned BLK_W = cnt_width(BLINK_FRAMES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [DIG_W-1:0] IDX_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [DIG_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  blink_phase_t            phase_q, phase_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frame_done_q;

  logic                    tick, wrap;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_zero, cur_blank;
  logic [7:0]              pattern;

  always_comb begin
    tick = (presc_q == PRE_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + DIG_W'(1);

    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (wrap) begin
      if (load) begin
        disp_data_d = data_in;
        disp_dp_d   = dp_in;
      end else if (pend_valid_q) begin
        disp_data_d = pend_data_q;
        disp_dp_d   = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_data_d  = data_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = PHASE_ON;
    end else if (frame_done_q) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    // zero_from[i]: nibble i and every more-significant nibble are zero.
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (disp_data_d[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      zero_from[NUM_DIGITS-1-i] = (disp_data_d[4*(NUM_DIGITS-1-i) +: 4] == 4'h0)
                                  && zero_from[NUM_DIGITS-i];
    end

    // The segment register is loaded from next-state index and display so
    // digit and seg_data always change on the same edge.
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_zero = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == DIG_W'(i)) begin
        cur_nib  = disp_data_d[4*i +: 4];
        cur_dp   = disp_dp_d[i];
        cur_zero = zero_from[i];
      end
    end
    cur_blank = blank_lz && (idx_d != '0) && cur_zero;
  end

  seg7_decoder u_decoder (
    .nibble  (cur_nib),
    .dp      (cur_dp),
    .blank   (cur_blank),
    .pattern (pattern)
  );

  always_comb begin
    seg_d = (phase_d == PHASE_OFF) ? SEG_OFF_H : pattern;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      blink_cnt_q  <= '0;
      phase_q      <= PHASE_ON;
      seg_q        <= SEG_OFF_H;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      frame_done_q <= wrap;
    end
  end

  assign digit      = idx_q;
  assign frame_done = frame_done_q;
  assign seg_data   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: expected per-slot digit/segment values
// are queued with the stimulus and consumed at the end of each scan slot.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 2;
  localparam int unsigned SD = 4;
  localparam int unsigned BF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   data_in = '0;
  logic [3:0]    dp_in = '0;
  logic          blank_lz = 1'b0;
  logic          blink_en = 1'b0;
  logic [DW-1:0] digit;
  logic [7:0]    seg_data;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [1:0] dig;
    logic [7:0] seg;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  bit          synced = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS     (ND),
    .DIG_W          (DW),
    .SCAN_DIV       (SD),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .digit      (digit),
    .seg_data   (seg_data),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // Slot sampler: last cycle of each digit slot, counted from frame_done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      cyc    = 0;
      synced = 1'b0;
    end else begin
      if (frame_done) begin
        cyc    = 0;
        synced = 1'b1;
      end else begin
        cyc++;
      end
      if (synced && (cyc % SD) == SD - 1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_digit"}, 8'(digit), 8'(e.dig));
        check({e.tag, "_seg"}, seg_data, e.seg);
      end
    end
  end

  task automatic wait_frame();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) check("frame_timeout", 8'(frame_done), 8'd1);
  endtask

  task automatic push_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    exp_q.push_back('{tag, 2'd0, s0});
    exp_q.push_back('{tag, 2'd1, s1});
    exp_q.push_back('{tag, 2'd2, s2});
    exp_q.push_back('{tag, 2'd3, s3});
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 8'(exp_q.size()), 8'd0);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
    wait_frame();
    push_frame(tag, s0, s1, s2, s3);
    drain();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    data_in = d;
    dp_in   = dp;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digit", 8'(digit), 8'd0);
    check("rst_seg", seg_data, 8'hFF);
    check("rst_fd", 8'(frame_done), 8'd0);
    rst = 1'b1;

    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      check("scan_digit", 8'(digit), 8'((n / 4) % 4));
      check("scan_fd", 8'(frame_done), (n % 16 == 0) ? 8'd1 : 8'd0);
    end

    wait_frame();
    push_frame("pre_load", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    do_load(16'h12A0, 4'h0);
    drain();
    expect_frame("load", 8'hC0, 8'h88, 8'hA4, 8'hF9);

    blank_lz = 1'b1;
    wait_frame();
    do_load(16'h0005, 4'h0);
    expect_frame("lz5", 8'h92, 8'hFF, 8'hFF, 8'hFF);
    wait_frame();
    do_load(16'h0000, 4'b0010);
    expect_frame("lz0", 8'hC0, 8'h7F, 8'hFF, 8'hFF);

    wait_frame();
    push_frame("pre_multi", 8'hC0, 8'h7F, 8'hFF, 8'hFF);
    do_load(16'h1111, 4'h0);
    repeat (4) @(negedge clk);
    do_load(16'h2222, 4'h0);
    drain();
    expect_frame("multi", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

    wait_frame();
    repeat (15) @(negedge clk);
    data_in = 16'h3333;
    dp_in   = 4'h0;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    check("wrap_fd", 8'(frame_done), 8'd1);
    push_frame("wrap_load", 8'hB0, 8'hB0, 8'hB0, 8'hB0);
    drain();

    wait_frame();
    @(negedge clk);
    blink_en = 1'b1;
    push_frame("blink_on0", 8'hB0, 8'hB0, 8'hB0, 8'hB0);
    push_frame("blink_on1", 8'hB0, 8'hB0, 8'hB0, 8'hB0);
    push_frame("blink_off0", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push_frame("blink_off1", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push_frame("blink_on2", 8'hB0, 8'hB0, 8'hB0, 8'hB0);
    repeat (6) wait_frame();
    check("blink_drain", 8'(exp_q.size()), 8'd0);
    @(negedge clk);
    check("blink_off_now", seg_data, 8'hFF);
    blink_en = 1'b0;
    @(negedge clk);
    check("blink_resume", seg_data, 8'hB0);
    check("blink_digit", 8'(digit), 8'd0);

    blank_lz = 1'b0;
    wait_frame();
    repeat (5) @(negedge clk);
    do_load(16'h5555, 4'hF);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_digit", 8'(digit), 8'd0);
    check("arst_seg", seg_data, 8'hFF);
    check("arst_fd", 8'(frame_done), 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    expect_frame("post_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised time-multiplexed seven-segment display controller, successor to the fixed 8-digit scan path at the top level. Latches an N-digit hex word plus decimal points, scans one digit per refresh tick, and drives digit/seg_data. Adds tear-free frame-boundary updates, leading-zero blanking, blinking, selectable segment polarity and a frame-done strobe. Sits between the result/state logic and the board display pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16)
DIG_W, 3, width of digit index output, must satisfy 2**DIG_W >= NUM_DIGITS
SCAN_DIV, 1000, clk cycles per digit slot (>=1)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
load  in  1  capture data_in/dp_in this cycle
data_in  in  4*NUM_DIGITS  hex nibbles, nibble 0 = rightmost (least significant) digit
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_lz  in  1  enable leading-zero blanking
blink_en  in  1  enable whole-display blinking
digit  out  DIG_W  binary index of digit currently driven
seg_data  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when the scan wraps from last digit to 0

Behaviour:
- Reset (rst=0, async): digit=0, seg_data=SEG_OFF (8'hFF active-low, 8'h00 active-high), frame_done=0, prescaler=0, display and pending registers=0, pending_valid=0, blink counter=0, blink phase=on.
- Prescaler counts 0..SCAN_DIV-1; tick asserted in cycle where count==SCAN_DIV-1, then wraps to 0. SCAN_DIV=1: tick every cycle.
- On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. digit and seg_data are registered and update together in the cycle following the tick; seg_data always reflects the new idx, never a mix.
- frame_done=1 in the cycle following a tick on which idx wrapped NUM_DIGITS-1 -> 0; otherwise 0.
- Load: load=1 writes data_in/dp_in into pending, sets pending_valid; repeated loads within a frame, last wins.
- Commit only at wrap tick: display <= load ? inputs : (pending_valid ? pending : display); pending_valid cleared. Load coinciding with the wrap tick commits directly that cycle. Display contents never change mid-frame.
- Decode: nibble 0-F -> standard hex glyphs (b,d lower case). dp bit from display dp.
- Leading-zero blanking (blank_lz=1): digit i blanked (all segments off, dp kept) when its nibble and every nibble of index >i are 0; digit 0 never blanked. blank_lz is sampled live, not committed.
- Blink: blink_en=0 holds counter at 0 and phase on. blink_en=1: counter increments per frame_done, at BLINK_FRAMES-1 wraps and toggles phase. Phase off forces seg_data=SEG_OFF including dp; digit keeps scanning.
- Polarity: internal active-high pattern inverted at output when SEG_ACTIVE_LOW=1.
- Reset mid-operation: all state returns to reset values immediately; pending load lost.

Decomposition:
- Package seg7_pkg: SEG_OFF_H constant, sixteen active-high glyph constants, segment bit-position constants, function widths helper.
- One sub-module: seg7_decoder (combinational nibble+dp+blank -> 8-bit active-high pattern). Scan, commit, blanking and blink logic stay in seg7_scan_ctrl.

Test Plan:
(NUM_DIGITS=4, DIG_W=2, SCAN_DIV=4, BLINK_FRAMES=2, SEG_ACTIVE_LOW=1)
1. Hold rst=0 -> digit=0, seg_data=8'hFF, frame_done=0; release -> digit steps 0,1,2,3,0 every 4 clk, frame_done single pulse with digit returning to 0.
2. load data_in=16'h12A0, dp_in=0 -> unchanged until next wrap; then digit0=8'hC0, digit1=8'h88, digit2=8'hA4, digit3=8'hF9.
3. blank_lz=1, load 16'h0005 -> digits 3,2,1 = 8'hFF, digit0=8'h92; load 16'h0000 -> digit0=8'hC0, others 8'hFF; dp_in=4'b0010 keeps digit1 = 8'h7F.
4. Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows 8'hA4 on all digits, 8'hF9 never displayed; load on wrap tick commits same frame.
5. blink_en=1 -> 2 frames normal, 2 frames all 8'hFF while digit still scans; blink_en=0 -> immediately normal.
6. Assert rst mid-frame after load -> digit=0, seg_data=8'hFF at once; after release, display shows 0 glyphs (8'hC0), pending load discarded.
